// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and IF->ID signals.
// The stage itself connects through the master modport. Memory, EX and Decode
// sit on the slave side.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect, redirect_pc,
    output id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect, redirect_pc,
    input  id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault,
    output id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the pipeline.
// The stage issues in-order word fetches and allows at most DEPTH requests
// in flight plus buffered. It queues the returned words in a DEPTH-entry FIFO
// whose head is the IF->ID register.
// A redirect flushes the FIFO and drops every response still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target raises a sticky fetch_fault and stops fetching.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0]   NOP_C   = 32'h0000_0013;
  localparam logic [31:0]   FOUR_C  = 32'h0000_0004;

  logic [31:0]      fetch_pc_r, fetch_pc_s;
  // PC of the next response that will be kept. Responses that are kept always
  // belong to the current sequential stream, so one counter replaces a tag queue.
  logic [31:0]      rsp_pc_r, rsp_pc_s;
  logic [CW-1:0]    outst_r, outst_s;
  logic [CW-1:0]    drop_r, drop_s;
  logic [CW-1:0]    count_r, count_s;
  logic             fault_r, fault_s;
  logic [DEPTH-1:0] ent_vld_r, ent_vld_s;
  logic [31:0]      ent_instr_r [DEPTH];
  logic [31:0]      ent_instr_s [DEPTH];
  logic [31:0]      ent_pc_r    [DEPTH];
  logic [31:0]      ent_pc_s    [DEPTH];
  logic [31:0]      ent_pc4_r   [DEPTH];
  logic [31:0]      ent_pc4_s   [DEPTH];

  logic             req_valid_s, acc_s, rsp_s, drop_now_s, push_s, pop_s, misalign_s;
  logic [31:0]      target_s;
  logic [CW-1:0]    wr_idx_s;

  // Handshake qualifiers, redirect target and FIFO write slot for this cycle
  always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
    target_s = bus.redirect_pc;
    if (bus.redirect) begin
      misalign_s = (bus.redirect_pc[1:0] != 2'b00);
    end else begin
      misalign_s = 1'b0;
    end
`else
    target_s   = bus.redirect_pc & 32'hFFFF_FFFC;
    misalign_s = 1'b0;
`endif
    // Gating with reset keeps the request low while reset is held.
    // Credits count requests in flight plus buffered words, so the FIFO cannot overflow.
    req_valid_s = reset && !bus.redirect && !fault_r &&
                  (({1'b0, outst_r} + {1'b0, count_r}) < DEPTH_C);
    acc_s       = req_valid_s && bus.imem_req_ready;
    rsp_s       = bus.imem_rsp_valid && (outst_r != ZERO_C);
    drop_now_s  = rsp_s && (drop_r != ZERO_C);
    push_s      = rsp_s && !drop_now_s && !bus.redirect;
    pop_s       = ent_vld_r[0] && bus.id_ready && !bus.redirect;
    wr_idx_s    = pop_s ? (count_r - ONE_C) : count_r;
  end

  // Credit, drop and occupancy counters, fetch/response PCs and the sticky fault
  always_comb begin
    if (acc_s && !rsp_s) begin
      outst_s = outst_r + ONE_C;
    end else if (!acc_s && rsp_s) begin
      outst_s = outst_r - ONE_C;
    end else begin
      outst_s = outst_r;
    end

    // Every request still in flight after a redirect belongs to the old stream.
    if (bus.redirect) begin
      drop_s = outst_s;
    end else if (drop_now_s) begin
      drop_s = drop_r - ONE_C;
    end else begin
      drop_s = drop_r;
    end

    if (bus.redirect) begin
      count_s = ZERO_C;
    end else if (push_s && !pop_s) begin
      count_s = count_r + ONE_C;
    end else if (!push_s && pop_s) begin
      count_s = count_r - ONE_C;
    end else begin
      count_s = count_r;
    end

    if (bus.redirect && !misalign_s) begin
      fetch_pc_s = target_s;
      rsp_pc_s   = target_s;
    end else begin
      fetch_pc_s = acc_s  ? (fetch_pc_r + FOUR_C) : fetch_pc_r;
      rsp_pc_s   = push_s ? (rsp_pc_r + FOUR_C)   : rsp_pc_r;
    end

    fault_s = fault_r || misalign_s;
  end

  // Shift FIFO. Entry 0 is always the head, so the id_* ports come straight from flops.
  always_comb begin
    ent_vld_s = ent_vld_r;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_instr_s[i] = ent_instr_r[i];
      ent_pc_s[i]    = ent_pc_r[i];
      ent_pc4_s[i]   = ent_pc4_r[i];
    end
    if (bus.redirect) begin
      ent_vld_s = {DEPTH{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_instr_s[i] = NOP_C;
        ent_pc_s[i]    = 32'h0000_0000;
        ent_pc4_s[i]   = 32'h0000_0000;
      end
      // After a trap the head reports the faulting target while id_valid stays low.
      if (misalign_s) begin
        ent_pc_s[0]  = bus.redirect_pc;
        ent_pc4_s[0] = bus.redirect_pc + FOUR_C;
      end else begin
        ent_pc_s[0]  = 32'h0000_0000;
        ent_pc4_s[0] = 32'h0000_0000;
      end
    end else begin
      if (pop_s) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          ent_vld_s[i]   = ent_vld_r[i+1];
          ent_instr_s[i] = ent_instr_r[i+1];
          ent_pc_s[i]    = ent_pc_r[i+1];
          ent_pc4_s[i]   = ent_pc4_r[i+1];
        end
        ent_vld_s[DEPTH-1]   = 1'b0;
        ent_instr_s[DEPTH-1] = NOP_C;
        ent_pc_s[DEPTH-1]    = 32'h0000_0000;
        ent_pc4_s[DEPTH-1]   = 32'h0000_0000;
      end else begin
        ent_vld_s = ent_vld_r;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push_s && (CW'(i) == wr_idx_s)) begin
          ent_vld_s[i]   = 1'b1;
          ent_instr_s[i] = bus.imem_rsp_data;
          ent_pc_s[i]    = rsp_pc_r;
          ent_pc4_s[i]   = rsp_pc_r + FOUR_C;
        end else begin
          ent_vld_s[i] = ent_vld_s[i];
        end
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
      outst_r    <= ZERO_C;
      drop_r     <= ZERO_C;
      count_r    <= ZERO_C;
      fault_r    <= 1'b0;
    end else begin
      fetch_pc_r <= fetch_pc_s;
      rsp_pc_r   <= rsp_pc_s;
      outst_r    <= outst_s;
      drop_r     <= drop_s;
      count_r    <= count_s;
      fault_r    <= fault_s;
    end
  end

  // FIFO storage. Empty entries hold a NOP with zero PCs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_vld_r <= {DEPTH{1'b0}};
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_instr_r[i] <= NOP_C;
        ent_pc_r[i]    <= 32'h0000_0000;
        ent_pc4_r[i]   <= 32'h0000_0000;
      end
    end else begin
      ent_vld_r <= ent_vld_s;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_instr_r[i] <= ent_instr_s[i];
        ent_pc_r[i]    <= ent_pc_s[i];
        ent_pc4_r[i]   <= ent_pc4_s[i];
      end
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign bus.id_valid       = ent_vld_r[0];
  assign bus.id_instr       = ent_instr_r[0];
  assign bus.id_pc          = ent_pc_r[0];
  assign bus.id_pc_plus4    = ent_pc4_r[0];
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.fetch_fault    = fault_r;
`else
  assign bus.fetch_fault    = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage.
// The driver process models instruction memory and the expected fetch stream.
// It tracks epochs: a redirect starts a new epoch, and words from older epochs
// must never reach Decode. The driver pushes each expected word into a queue.
// A separate monitor pops that queue whenever Decode accepts an instruction.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct { int due; logic [31:0] data; int epoch; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus();
  fetch_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  int          vectors = 0, miscompares = 0;
  int          cyc = 0, last_due = 0, epoch = 0, ret_cnt = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] model_pc = RST_PC;
  logic        fault_m = 1'b0;
  logic        mon_en = 1'b0;
  logic        s_id_valid;
  logic [31:0] s_id_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("rst_id_instr", bus.id_instr, NOP);
    check("rst_id_pc", bus.id_pc, 32'd0);
    check("rst_id_pc4", bus.id_pc_plus4, 32'd0);
    check("rst_fault", 32'(bus.fetch_fault), 32'd0);
  endtask

  task automatic clear_model();
    mem_q.delete();
    exp_q.delete();
    ret_cnt  = 0;
    model_pc = RST_PC;
    fault_m  = 1'b0;
    epoch++;
  endtask

  // One clock cycle: drive inputs at negedge, check at +1, advance the model across the edge.
  task automatic step(input logic rdy, input logic idr, input logic redir, input logic [31:0] rpc);
    mreq_t r;
    logic  rsp, exp_rv, popped;
    int    lat, due;
    @(negedge clk);
    r   = '{due: 0, data: 32'h0, epoch: 0};
    rsp = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r   = mem_q.pop_front();
      rsp = 1'b1;
    end
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? r.data : $urandom();
    bus.imem_req_ready = rdy;
    bus.id_ready       = idr;
    bus.redirect       = redir;
    bus.redirect_pc    = redir ? rpc : $urandom();
    #1;
    s_id_valid = bus.id_valid;
    s_id_pc    = bus.id_pc;
    exp_rv = !redir && !fault_m && ((mem_q.size() + (rsp ? 1 : 0) + ret_cnt) < DEPTH);
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv && bus.imem_req_valid) check("req_addr", bus.imem_req_addr, model_pc);
    check("id_valid", 32'(bus.id_valid), 32'(ret_cnt != 0));
    if (!bus.id_valid) check("idle_instr", bus.id_instr, NOP);
    check("fetch_fault", 32'(bus.fetch_fault), 32'(fault_m));
    if (redir) begin
      epoch++;
      exp_q.delete();
      ret_cnt = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (rpc[1:0] != 2'b00) fault_m = 1'b1;
      else model_pc = rpc;
`else
      model_pc = {rpc[31:2], 2'b00};
`endif
    end else begin
      popped = (ret_cnt != 0) && idr;
      if (popped) ret_cnt--;
      if (rsp && r.epoch == epoch) ret_cnt++;
      if (exp_rv && rdy) begin
        lat = int'($urandom_range(lat_max, lat_min));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{due: due, data: mem_word(model_pc), epoch: epoch});
        exp_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  // Run until the first valid IF->ID word appears and check its PC, within a cycle budget.
  task automatic wait_id(input string name, input logic [31:0] pc, input int budget);
    int n = 0;
    do begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end while (!s_id_valid && n < budget);
    if (s_id_valid) check(name, s_id_pc, pc);
    else begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no valid instruction within %0d cycles, expected pc %08h", name, budget, pc);
    end
  endtask

  task automatic random_run(input int n, input int redir_pct);
    logic [31:0] t;
    for (int k = 0; k < n; k++) begin
      t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(3, 0) * 4))
                                       : ($urandom() & 32'h0000_FFFC);
      step($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70,
           $urandom_range(99, 0) < redir_pct, t);
    end
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #3;
    reset  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect       = 1'b0;
    bus.id_ready       = 1'b0;
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares each word Decode accepts against the scoreboard and checks stall stability.
  initial begin
    logic        hold;
    logic [31:0] h_instr, h_pc, h_pc4;
    exp_t        e;
    hold = 1'b0;
    h_instr = 32'h0; h_pc = 32'h0; h_pc4 = 32'h0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) hold = 1'b0;
      else begin
        if (hold) begin
          check("stall_valid", 32'(bus.id_valid), 32'd1);
          check("stall_instr", bus.id_instr, h_instr);
          check("stall_pc", bus.id_pc, h_pc);
          check("stall_pc4", bus.id_pc_plus4, h_pc4);
        end
        if (bus.id_valid && bus.id_ready && !bus.redirect) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got pc %08h, expected no instruction", bus.id_pc);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", bus.id_pc, e.pc);
            check("out_instr", bus.id_instr, e.instr);
            check("out_pc4", bus.id_pc_plus4, e.pc + 32'd4);
          end
        end
        hold    = bus.id_valid && !bus.id_ready && !bus.redirect;
        h_instr = bus.id_instr;
        h_pc    = bus.id_pc;
        h_pc4   = bus.id_pc_plus4;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs();
    reset  = 1'b1;
    mon_en = 1'b1;

    // Latency 1, always ready: first word reaches ID two cycles after its request is accepted.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_id_valid", 32'(s_id_valid), 32'd1);
    check("first_id_pc", s_id_pc, RST_PC);
    repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stalls: FIFO fills, requests stop, then the stream resumes in order.
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("full_req_stopped", 32'(bus.imem_req_valid), 32'd0);
    check("full_id_valid", 32'(s_id_valid), 32'd1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Latency 3 with two requests in flight, then a redirect.
    lat_min = 3; lat_max = 3;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    wait_id("redirect_target", 32'h0000_0100, 20);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect while a response lands in the same cycle.
    lat_min = 1; lat_max = 1;
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    wait_id("redirect_with_rsp", 32'h0000_0200, 20);

    // Address wrap at the top of memory.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    wait_id("wrap_top", 32'hFFFF_FFFC, 20);
    wait_id("wrap_zero", 32'h0000_0000, 20);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect target.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("trap_fault", 32'(bus.fetch_fault), 32'd1);
    check("trap_id_pc", bus.id_pc, 32'h0000_0102);
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    reset_mid();
`else
    wait_id("misalign_trunc", 32'h0000_0100, 20);
`endif

    // Randomised traffic with varying latency, and an asynchronous reset during a burst.
    lat_min = 1; lat_max = 4;
    random_run(300, 5);
    reset_mid();
    lat_min = 1; lat_max = 2;
    random_run(300, 3);
    lat_min = 2; lat_max = 6;
    random_run(300, 8);

    // Drain: stop new requests and expect every outstanding word to be delivered.
    repeat (25) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("drain_all_delivered", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
